// File: rtl/binary_score_ctrl.sv
// binary_score_ctrl: sequencer for the 4-head binary attention-score unit.
// Shadows the key matrix, then scores and streams one query row at a time.
module binary_score_ctrl #(
   parameter int SEQ_LEN = 30,
   parameter int D_MODEL = 16,
   parameter int N_HEAD  = 4,
   parameter int SC_LAT  = 1,
   parameter int AW      = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   output logic                        busy,
   output logic                        done,
   output logic                        k_rd_en,
   output logic [AW-1:0]               k_rd_addr,
   input  logic [D_MODEL-1:0]          k_rd_data,
   output logic                        q_rd_en,
   output logic [AW-1:0]               q_rd_addr,
   input  logic [D_MODEL-1:0]          q_rd_data,
   output logic [D_MODEL-1:0]          sc_query,
   output logic [SEQ_LEN*D_MODEL-1:0]  sc_key,
   output logic                        sc_valid,
   input  logic [N_HEAD*SEQ_LEN-1:0]   sc_score,
   output logic [N_HEAD*SEQ_LEN-1:0]   out_data,
   output logic [AW-1:0]               out_row,
   output logic                        out_valid,
   input  logic                        out_ready
);

   typedef enum logic [2:0] {
      IDLE, LOAD_K, READ_Q, ISSUE, WAIT, CAPTURE, OUTPUT, FIN
   } state_t;

   localparam int LW = $clog2(SEQ_LEN + 1);
   localparam int WAIT_N = (SC_LAT > 1) ? SC_LAT - 2 : 0;
   localparam logic [LW-1:0] LD_LAST = LW'(SEQ_LEN);
   localparam logic [AW-1:0] ROW_LAST = AW'(SEQ_LEN - 1);
   localparam logic [2:0] WAIT_LAST = 3'(WAIT_N);

   state_t state, nstate;
   logic [LW-1:0] ld_cnt;
   logic [AW-1:0] row;
   logic [2:0] wcnt;
   logic k_wr_en;
   logic [AW-1:0] k_wr_addr;
   logic [D_MODEL-1:0] q_hold;

   assign busy = (state != IDLE);
   assign k_rd_addr = k_rd_en ? AW'(ld_cnt) : '0;
   assign q_rd_addr = q_rd_en ? row : '0;
   // The score unit sees the fresh query in the same cycle as sc_valid.
   assign sc_query = (state == ISSUE) ? q_rd_data : q_hold;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   // Next state and single-cycle strobes; abort overrides everything.
   always_comb begin
      nstate   = state;
      k_rd_en  = 1'b0;
      q_rd_en  = 1'b0;
      sc_valid = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: if (start) nstate = LOAD_K;
         LOAD_K: begin
            k_rd_en = (ld_cnt != LD_LAST);
            if (ld_cnt == LD_LAST) nstate = READ_Q;
         end
         READ_Q: begin
            q_rd_en = 1'b1;
            nstate  = ISSUE;
         end
         ISSUE: begin
            sc_valid = 1'b1;
            nstate   = (SC_LAT > 1) ? WAIT : CAPTURE;
         end
         WAIT: if (wcnt == WAIT_LAST) nstate = CAPTURE;
         CAPTURE: nstate = OUTPUT;
         OUTPUT: begin
            if (out_ready) nstate = (row == ROW_LAST) ? FIN : READ_Q;
         end
         FIN: begin
            done   = 1'b1;
            nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
      if (abort) begin
         nstate   = IDLE;
         k_rd_en  = 1'b0;
         q_rd_en  = 1'b0;
         sc_valid = 1'b0;
         done     = 1'b0;
      end
   end

   // Load, row and latency counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt <= '0;
         row    <= '0;
         wcnt   <= '0;
      end else begin
         if (state == LOAD_K && !abort && ld_cnt != LD_LAST)
            ld_cnt <= ld_cnt + LW'(1);
         else
            ld_cnt <= '0;
         if (abort || state == IDLE || state == LOAD_K)
            row <= '0;
         else if (state == OUTPUT && out_ready && row != ROW_LAST)
            row <= row + AW'(1);
         if (state == WAIT && !abort && wcnt != WAIT_LAST)
            wcnt <= wcnt + 3'd1;
         else
            wcnt <= '0;
      end
   end

   // Key shadow: memory data lands one cycle after its read strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_wr_en   <= 1'b0;
         k_wr_addr <= '0;
         sc_key    <= '0;
      end else begin
         k_wr_en   <= k_rd_en;
         k_wr_addr <= k_rd_addr;
         if (k_wr_en)
            sc_key[int'(k_wr_addr)*D_MODEL +: D_MODEL] <= k_rd_data;
      end
   end

   // Query hold and result register with valid/ready handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_hold    <= '0;
         out_data  <= '0;
         out_row   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (state == ISSUE) q_hold <= q_rd_data;
         if (abort) begin
            out_valid <= 1'b0;
         end else if (state == CAPTURE) begin
            out_data  <= sc_score;
            out_row   <= row;
            out_valid <= 1'b1;
         end else if (state == OUTPUT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_binary_score_ctrl.sv
// tb_binary_score_ctrl: scoreboard bench for binary_score_ctrl.
// Two instances: SC_LAT=1 with a scoring stub, SC_LAT=3 with a time-stamp stub.
module tb_binary_score_ctrl;

   localparam int SEQ_LEN = 30;
   localparam int D_MODEL = 16;
   localparam int N_HEAD  = 4;
   localparam int AW      = 5;
   localparam int SW      = N_HEAD * SEQ_LEN;
   localparam int KW      = SEQ_LEN * D_MODEL;

   typedef struct {
      logic [AW-1:0] row;
      logic [SW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   logic [D_MODEL-1:0] kmem [SEQ_LEN];
   logic [D_MODEL-1:0] qmem [SEQ_LEN];

   // instance A signals
   logic start_a, abort, out_ready_a;
   logic a_busy, a_done, a_k_rd_en, a_q_rd_en, a_sc_valid, a_out_valid;
   logic [AW-1:0] a_k_rd_addr, a_q_rd_addr, a_out_row;
   logic [D_MODEL-1:0] a_k_rd_data, a_q_rd_data, a_sc_query;
   logic [KW-1:0] a_sc_key;
   logic [SW-1:0] a_sc_score, a_out_data;

   // instance B signals
   logic start_b;
   logic abort_b = 1'b0;
   logic out_ready_b = 1'b1;
   logic b_busy, b_done, b_k_rd_en, b_q_rd_en, b_sc_valid, b_out_valid;
   logic [AW-1:0] b_k_rd_addr, b_q_rd_addr, b_out_row;
   logic [D_MODEL-1:0] b_k_rd_data, b_q_rd_data, b_sc_query;
   logic [KW-1:0] b_sc_key;
   logic [SW-1:0] b_sc_score, b_out_data;

   binary_score_ctrl #(.SC_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
      .busy(a_busy), .done(a_done),
      .k_rd_en(a_k_rd_en), .k_rd_addr(a_k_rd_addr), .k_rd_data(a_k_rd_data),
      .q_rd_en(a_q_rd_en), .q_rd_addr(a_q_rd_addr), .q_rd_data(a_q_rd_data),
      .sc_query(a_sc_query), .sc_key(a_sc_key), .sc_valid(a_sc_valid),
      .sc_score(a_sc_score), .out_data(a_out_data), .out_row(a_out_row),
      .out_valid(a_out_valid), .out_ready(out_ready_a)
   );

   binary_score_ctrl #(.SC_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .busy(b_busy), .done(b_done),
      .k_rd_en(b_k_rd_en), .k_rd_addr(b_k_rd_addr), .k_rd_data(b_k_rd_data),
      .q_rd_en(b_q_rd_en), .q_rd_addr(b_q_rd_addr), .q_rd_data(b_q_rd_data),
      .sc_query(b_sc_query), .sc_key(b_sc_key), .sc_valid(b_sc_valid),
      .sc_score(b_sc_score), .out_data(b_out_data), .out_row(b_out_row),
      .out_valid(b_out_valid), .out_ready(out_ready_b)
   );

   task automatic check(input string name, input logic [511:0] act,
                        input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Head score bit: at least 3 of 4 bits of the head slice agree.
   function automatic logic [SW-1:0] score_fn(input logic [D_MODEL-1:0] q,
                                               input logic [KW-1:0] kf);
      logic [SW-1:0] s;
      int agree;
      s = '0;
      for (int h = 0; h < N_HEAD; h++)
         for (int r = 0; r < SEQ_LEN; r++) begin
            agree = 0;
            for (int b = 0; b < 4; b++)
               if (q[h*4+b] == kf[r*D_MODEL+h*4+b]) agree++;
            s[h*SEQ_LEN+r] = (agree >= 3);
         end
      return s;
   endfunction

   function automatic logic [SW-1:0] stamp(input int unsigned c);
      logic [SW-1:0] s;
      for (int h = 0; h < N_HEAD; h++)
         s[h*SEQ_LEN +: SEQ_LEN] = 30'((c << 2) ^ 32'(h));
      return s;
   endfunction

   function automatic logic [KW-1:0] key_flat();
      logic [KW-1:0] f;
      for (int r = 0; r < SEQ_LEN; r++) f[r*D_MODEL +: D_MODEL] = kmem[r];
      return f;
   endfunction

   // memories and score stubs
   always @(posedge clk) begin
      if (a_k_rd_en) a_k_rd_data <= kmem[a_k_rd_addr];
      if (a_q_rd_en) a_q_rd_data <= qmem[a_q_rd_addr];
      if (b_k_rd_en) b_k_rd_data <= kmem[b_k_rd_addr];
      if (b_q_rd_en) b_q_rd_data <= qmem[b_q_rd_addr];
      a_sc_score <= a_sc_valid ? score_fn(a_sc_query, a_sc_key) : '0;
   end
   assign b_sc_score = stamp(cyc);

   // downstream back-pressure driver for instance A
   int stall_row = -1;
   int stall_left = 0;
   initial begin
      out_ready_a = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (a_out_valid && int'(a_out_row) == stall_row && stall_left > 0) begin
            out_ready_a = 1'b0;
            stall_left--;
         end else begin
            out_ready_a = 1'b1;
         end
      end
   end

   exp_t qa[$];
   logic [SW-1:0] qb[$];
   int exp_fetch = -1;
   int sv_idx = 0;
   int n_done_a = 0;
   int unsigned t_done_a = 0;
   int b_row_exp = 0;
   int n_done_b = 0;
   int unsigned t_done_b = 0;

   // monitor A: results, stall stability, next fetch / done timing
   always @(negedge clk) begin
      if (a_done) begin
         n_done_a++;
         t_done_a = cyc;
      end
      if (exp_fetch >= 0) begin
         if (exp_fetch == SEQ_LEN) begin
            check("done_after_last", a_done, 1);
         end else begin
            check("fetch_en", a_q_rd_en, 1);
            check("fetch_addr", a_q_rd_addr, exp_fetch);
         end
         exp_fetch = -1;
      end
      if (a_out_valid) begin
         check("queue_nonempty", qa.size() > 0, 1);
         if (qa.size() > 0) begin
            check("out_row", a_out_row, qa[0].row);
            check("out_data", a_out_data, qa[0].data);
            if (!out_ready_a) begin
               check("stall_no_fetch", a_q_rd_en, 0);
            end else begin
               exp_fetch = int'(qa[0].row) + 1;
               void'(qa.pop_front());
            end
         end
      end
      if (a_sc_valid && sv_idx < SEQ_LEN) begin
         check("sc_query", a_sc_query, qmem[sv_idx]);
         check("sc_key", a_sc_key, key_flat());
      end
      if (a_sc_valid) sv_idx++;
   end

   // monitor B: capture point exactly 3 cycles after sc_valid
   always @(negedge clk) begin
      if (b_done) begin
         n_done_b++;
         t_done_b = cyc;
      end
      if (b_sc_valid) qb.push_back(stamp(cyc + 3));
      if (b_out_valid) begin
         check("b_queue_nonempty", qb.size() > 0, 1);
         if (qb.size() > 0) begin
            check("b_sample_point", b_out_data, qb[0]);
            check("b_row", b_out_row, b_row_exp);
            void'(qb.pop_front());
            b_row_exp++;
         end
      end
   end

   task automatic push_rows(input int n);
      for (int r = 0; r < n; r++)
         qa.push_back('{row: AW'(r), data: score_fn(qmem[r], key_flat())});
   endtask

   task automatic run_a(input int exp_cyc, input bit pulse_busy);
      int d0;
      int unsigned t0;
      push_rows(SEQ_LEN);
      sv_idx = 0;
      d0 = n_done_a;
      start_a = 1'b1;
      t0 = cyc;
      @(negedge clk);
      for (int k = 0; k < 600 && n_done_a == d0; k++) begin
         start_a = pulse_busy && (k == 10 || k == 100);
         @(negedge clk);
      end
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      check("done_count", n_done_a - d0, 1);
      if (n_done_a != d0) check("done_latency", t_done_a - t0, exp_cyc);
      check("sc_valid_count", sv_idx, SEQ_LEN);
      check("rows_left", qa.size(), 0);
      check("busy_after", a_busy, 0);
      qa.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int d0;
      int unsigned t0;
      bit found;
      start_a = 1'b0;
      start_b = 1'b0;
      abort = 1'b0;
      for (int r = 0; r < SEQ_LEN; r++) begin
         kmem[r] = '0;
         qmem[r] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_k_rd_en", a_k_rd_en, 0);
      check("rst_q_rd_en", a_q_rd_en, 0);
      check("rst_sc_valid", a_sc_valid, 0);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data", a_out_data, 0);
      check("rst_out_row", a_out_row, 0);
      check("rst_sc_key", a_sc_key, 0);
      check("rst_sc_query", a_sc_query, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // zero keys, all-ones queries
      for (int r = 0; r < SEQ_LEN; r++) qmem[r] = {4{4'hF}};
      run_a(152, 1'b0);

      // patterned keys/queries, row 7 stalled for 5 cycles
      for (int r = 0; r < SEQ_LEN; r++) begin
         kmem[r] = 16'(r * 16'h0101);
         qmem[r] = 16'(r * 16'h2b3d) ^ 16'h5a0f;
      end
      stall_row = 7;
      stall_left = 5;
      run_a(157, 1'b0);
      check("stall_consumed", stall_left, 0);
      stall_row = -1;

      // SC_LAT=3 instance
      b_row_exp = 0;
      d0 = n_done_b;
      start_b = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < 600 && n_done_b == d0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("b_done_count", n_done_b - d0, 1);
      if (n_done_b != d0) check("b_done_latency", t_done_b - t0, 212);
      check("b_rows", b_row_exp, SEQ_LEN);
      check("b_rows_left", qb.size(), 0);

      // abort while row 12 sits in OUTPUT
      push_rows(13);
      sv_idx = 0;
      stall_row = 12;
      stall_left = 1000;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         found = a_out_valid && a_out_row == 5'd12;
      end
      check("row12_reached", found, 1);
      repeat (2) @(negedge clk);
      d0 = n_done_a;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      stall_left = 0;
      stall_row = -1;
      @(negedge clk);
      check("abort_busy", a_busy, 0);
      check("abort_out_valid", a_out_valid, 0);
      repeat (5) @(negedge clk);
      check("abort_no_done", n_done_a - d0, 0);
      check("abort_rows_left", qa.size(), 1);
      qa.delete();

      // fresh job after abort, start pulsed again while busy
      for (int r = 0; r < SEQ_LEN; r++) kmem[r] = ~16'(r * 16'h0101);
      run_a(152, 1'b1);

      // start and abort together in IDLE
      start_a = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", a_busy, 0);
      @(negedge clk);
      check("start_abort_busy2", a_busy, 0);

      // reset in the middle of LOAD_K
      d0 = n_done_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (8) @(negedge clk);
      check("midload_busy", a_busy, 1);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", a_busy, 0);
      check("mrst_k_rd_en", a_k_rd_en, 0);
      check("mrst_sc_key", a_sc_key, 0);
      check("mrst_out_valid", a_out_valid, 0);
      check("mrst_out_data", a_out_data, 0);
      check("mrst_sc_query", a_sc_query, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("mrst_idle", a_busy, 0);
      check("mrst_no_done", n_done_a - d0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
